conv_token_streamer: RTL and testbench

Reads the 56×56×96 patch-embedding feature map back out of output memory and streams it to the next stage as channel-contiguous tokens. It is the consumer of output memory, which the convolution controller fills in kernel-major (CHW) order. This block reorders to pixel-major (HWC): for each output pixel in raster order it emits all channels, then moves to the next pixel. Output is a valid/ready stream with token and frame markers; memory reads use the same 1-cycle-latency read port as the rest of the engine.

---
 rtl/conv_token_streamer_pkg.sv | 25 ++
 rtl/conv_token_streamer_if.sv | 32 +++
 rtl/conv_token_streamer_fifo.sv | 67 ++++++
 rtl/conv_token_streamer.sv | 141 ++++++++++++++
 tb/tb_conv_token_streamer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_token_streamer_pkg.sv
// Shared definitions for the convolution engine output side.
// Holds the default feature-map geometry, the data word width, the
// streamer state encoding and the sideband carried alongside each token word.
package conv_pkg;

  localparam int OUT_H       = 56;
  localparam int OUT_W       = 56;
  localparam int N_K         = 96;
  localparam int OUT_K_WORDS = OUT_H * OUT_W;
  localparam int DW          = 32;
  localparam int FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } strm_state_t;

  typedef struct packed {
    logic last;
    logic frame_last;
  } tok_sb_t;

endpackage

// File: rtl/conv_token_streamer_if.sv
// Token stream handshake between the streamer and the next stage.
//   tok_valid      : head word valid (producer)
//   tok_ready      : consumer accepts the head word
//   tok_data       : channel value
//   tok_last       : word is the final channel of its pixel
//   tok_frame_last : word is the final channel of the final pixel
// master = producer (streamer), slave = consumer.
interface conv_token_streamer_if #(
  parameter int DW = conv_pkg::DW
);
  logic          tok_valid;
  logic          tok_ready;
  logic [DW-1:0] tok_data;
  logic          tok_last;
  logic          tok_frame_last;

  modport master (
    output tok_valid,
    output tok_data,
    output tok_last,
    output tok_frame_last,
    input  tok_ready
  );

  modport slave (
    input  tok_valid,
    input  tok_data,
    input  tok_last,
    input  tok_frame_last,
    output tok_ready
  );
endinterface

// File: rtl/conv_token_streamer_fifo.sv
// conv_tok_fifo: 2-entry synchronous FIFO of {sideband, data}.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_sb/data  : write one entry
//   pop                 : consume the head entry (only while head_valid)
//   head_valid/sb/data  : current head entry
//   cnt                 : number of stored entries (0..2)
module conv_tok_fifo
  import conv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  tok_sb_t       push_sb,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          head_valid,
  output tok_sb_t       head_sb,
  output logic [DW-1:0] head_data,
  output logic [1:0]    cnt
);

  logic [DW-1:0] data_q [2];
  tok_sb_t       sb_q   [2];
  logic          wr_ptr;
  logic          rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      sb_q[0]   <= '0;
      sb_q[1]   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        sb_q[wr_ptr]   <= push_sb;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // The issue rule upstream bounds occupancy, so a push into a full FIFO
  // means that rule has been broken.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && cnt == 2'd2));
    end
  end

  assign head_valid = (cnt != 2'd0);
  assign head_data  = data_q[rd_ptr];
  assign head_sb    = sb_q[rd_ptr];

endmodule

// File: rtl/conv_token_streamer.sv
// conv_token_streamer: reads the CHW feature map out of output memory and
// streams it pixel-major (all channels of a pixel, then the next pixel).
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle pulse, begins a frame (ignored while busy)
//   busy, done     : frame in progress / one-cycle completion pulse
//   omem_rd_*      : 1-cycle-latency memory read port
//   tok            : token stream (valid/ready, data, last, frame_last)
module conv_token_streamer #(
  parameter int N_K   = conv_pkg::N_K,
  parameter int OUT_H = conv_pkg::OUT_H,
  parameter int OUT_W = conv_pkg::OUT_W,
  parameter int DW    = conv_pkg::DW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  omem_rd_addr,
  output logic                         omem_rd_en,
  input  logic [DW-1:0]                omem_rd_data,
  conv_token_streamer_if.master        tok
);
  import conv_pkg::*;

  localparam int          PIX      = OUT_H * OUT_W;
  localparam logic [31:0] K_STRIDE = 32'(PIX);
  localparam logic [31:0] PIX_LAST = 32'(PIX - 1);
  localparam int          KW       = (N_K > 1) ? $clog2(N_K) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_K - 1);

  strm_state_t   state, state_nx;
  logic [KW-1:0] k;
  logic [31:0]   pix_base;
  logic [31:0]   addr;
  logic          rd_pending;
  tok_sb_t       tag_p1;
  logic          pop;
  logic [1:0]    fifo_cnt;
  logic          fifo_valid;
  tok_sb_t       head_sb;
  logic [DW-1:0] head_data;
  logic          k_last;
  logic          frame_final;
  logic [2:0]    occ;

  assign pop         = fifo_valid && tok.tok_ready;
  assign k_last      = (k == K_LAST);
  assign frame_final = k_last && (pix_base == PIX_LAST);

  // Words stored plus the one in flight; a pop this cycle frees a slot,
  // hence the deliberate combinational tok_ready -> omem_rd_en path.
  assign occ        = {1'b0, fifo_cnt} + {2'b00, rd_pending};
  assign omem_rd_en = (state == S_RUN) && (occ < (3'd2 + {2'b00, pop}));

  assign omem_rd_addr = addr;
  assign busy         = (state == S_RUN) || (state == S_DRAIN);
  assign done         = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (omem_rd_en && frame_final) state_nx = S_DRAIN;
      // Leave as the final word is accepted so done lands the next cycle.
      S_DRAIN: if (!rd_pending && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop)))
                 state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Address walk: channel stride inside a pixel, restart at the next
  // pixel base once all channels are issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      pix_base <= '0;
      addr     <= '0;
    end else if (state == S_IDLE && start) begin
      k        <= '0;
      pix_base <= '0;
      addr     <= '0;
    end else if (omem_rd_en) begin
      if (frame_final) begin
        k        <= '0;
        pix_base <= '0;
        addr     <= '0;
      end else if (k_last) begin
        k        <= '0;
        pix_base <= pix_base + 32'd1;
        addr     <= pix_base + 32'd1;
      end else begin
        k    <= k + KW'(1);
        addr <= addr + K_STRIDE;
      end
    end
  end

  // Stage p1: tag of the read in flight, joined with read data next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      tag_p1     <= '0;
    end else begin
      rd_pending <= omem_rd_en;
      if (omem_rd_en) begin
        tag_p1 <= '{last: k_last, frame_last: frame_final};
      end
    end
  end

  conv_tok_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pending),
    .push_sb   (tag_p1),
    .push_data (omem_rd_data),
    .pop       (pop),
    .head_valid(fifo_valid),
    .head_sb   (head_sb),
    .head_data (head_data),
    .cnt       (fifo_cnt)
  );

  assign tok.tok_valid      = fifo_valid;
  assign tok.tok_data       = head_data;
  assign tok.tok_last       = head_sb.last;
  assign tok.tok_frame_last = head_sb.frame_last;

endmodule

// File: tb/tb_conv_token_streamer.sv
// Bench for conv_token_streamer on a reduced map (3 channels, 2x4 pixels).
// Expected tokens come from a pixel-major walk of a memory model; a monitor
// compares every handshake against that queue.
module tb_conv_token_streamer;
  localparam int NK    = 3;
  localparam int OH    = 2;
  localparam int OW    = 4;
  localparam int DWT   = 32;
  localparam int PIXN  = OH * OW;
  localparam int WORDS = NK * PIXN;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        fl;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            omem_rd_en;
  logic [31:0]     omem_rd_addr;
  logic [DWT-1:0]  omem_rd_data = '0;

  conv_token_streamer_if #(.DW(DWT)) tok_if ();

  conv_token_streamer #(
    .N_K(NK), .OUT_H(OH), .OUT_W(OW), .DW(DWT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .omem_rd_addr(omem_rd_addr),
    .omem_rd_en  (omem_rd_en),
    .omem_rd_data(omem_rd_data),
    .tok         (tok_if.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] salt = 12'h0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + {salt, 20'h0};
  endfunction

  // Memory model: 1-cycle read latency.
  always @(posedge clk) if (omem_rd_en) omem_rd_data <= mem_word(omem_rd_addr);

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Reference: pixel-major walk over a CHW memory image.
  task automatic push_expected();
    for (int p = 0; p < PIXN; p++) begin
      for (int k = 0; k < NK; k++) begin
        exp_q.push_back('{d: mem_word(32'(k * PIXN + p)),
                          l: (k == NK - 1),
                          fl: (k == NK - 1) && (p == PIXN - 1)});
      end
    end
  endtask

  // Monitor statistics
  int          hs_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int          done_cyc = 0, vrise_cyc = 0, rdrise_cyc = 0, last_rd_cyc = 0;
  logic [31:0] rdrise_addr = '0;
  logic        busy_at_done = 1'b0;

  initial begin : monitor
    logic        prev_v, prev_rd, prev_stall;
    logic [31:0] st_data;
    logic [1:0]  st_mark;
    exp_t        e;
    prev_v = 0; prev_rd = 0; prev_stall = 0; st_data = '0; st_mark = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0; prev_rd = 0; prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(tok_if.tok_valid), 32'd1);
          chk("stall_data", tok_if.tok_data, st_data);
          chk("stall_marks", 32'({tok_if.tok_last, tok_if.tok_frame_last}), 32'(st_mark));
        end
        if (tok_if.tok_valid && tok_if.tok_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", tok_if.tok_data, 32'hDEAD_BEEF ^ tok_if.tok_data);
          end else begin
            e = exp_q.pop_front();
            chk("tok_data", tok_if.tok_data, e.d);
            chk("tok_last", 32'(tok_if.tok_last), 32'(e.l));
            chk("tok_frame_last", 32'(tok_if.tok_frame_last), 32'(e.fl));
          end
        end
        prev_stall = tok_if.tok_valid && !tok_if.tok_ready;
        st_data    = tok_if.tok_data;
        st_mark    = {tok_if.tok_last, tok_if.tok_frame_last};
        if (tok_if.tok_valid && !prev_v) vrise_cyc = cyc;
        prev_v = tok_if.tok_valid;
        if (omem_rd_en) begin
          rd_cnt++;
          last_rd_cyc = cyc;
          if (!prev_rd) begin
            rdrise_cyc  = cyc;
            rdrise_addr = omem_rd_addr;
          end
        end
        prev_rd = omem_rd_en;
        if (done) begin
          done_cnt++;
          done_cyc     = cyc;
          busy_at_done = busy;
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd_en"}, 32'(omem_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, omem_rd_addr, 32'd0);
    chk({tag, "_tok_valid"}, 32'(tok_if.tok_valid), 32'd0);
    chk({tag, "_tok_last"}, 32'(tok_if.tok_last), 32'd0);
    chk({tag, "_tok_frame_last"}, 32'(tok_if.tok_frame_last), 32'd0);
    chk({tag, "_tok_data"}, tok_if.tok_data, 32'd0);
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int base_done, input bit rnd,
                           input int inject_at, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != base_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rnd) tok_if.tok_ready = 1'($urandom_range(0, 1));
      start = (cyc - t0 == inject_at);
    end
    start = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done pulse within 3000 cycles of start at %0d", t0);
    end
  endtask

  task automatic run_timed_frame(input string tag);
    int t0, hs0, rd0, d0;
    bit ok;
    salt = 12'($urandom);
    push_expected();
    hs0 = hs_cnt; rd0 = rd_cnt; d0 = done_cnt;
    tok_if.tok_ready = 1'b1;
    pulse_start(t0);
    chk({tag, "_busy_run"}, 32'(busy), 32'd1);
    wait_done(t0, d0, 1'b0, -1, ok);
    if (ok) begin
      chk({tag, "_first_rd_cyc"}, 32'(rdrise_cyc - t0), 32'd1);
      chk({tag, "_first_rd_addr"}, rdrise_addr, 32'd0);
      chk({tag, "_first_valid_cyc"}, 32'(vrise_cyc - t0), 32'd3);
      chk({tag, "_last_rd_cyc"}, 32'(last_rd_cyc - t0), 32'(WORDS));
      chk({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(WORDS));
      chk({tag, "_words"}, 32'(hs_cnt - hs0), 32'(WORDS));
      chk({tag, "_done_cyc"}, 32'(done_cyc - t0), 32'(WORDS + 3));
      chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stimulus
    int t0, d0, hs0, rd0, rel;
    bit ok;
    tok_if.tok_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // Full-throughput frame with timing checks.
    run_timed_frame("ready1");

    // Random 50% backpressure, with a stray start pulse mid-frame.
    salt = 12'($urandom);
    push_expected();
    hs0 = hs_cnt; d0 = done_cnt;
    pulse_start(t0);
    wait_done(t0, d0, 1'b1, 10, ok);
    tok_if.tok_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_words", 32'(hs_cnt - hs0), 32'(WORDS));
    chk("bp_done_count", 32'(done_cnt - d0), 32'd1);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Consumer stalled for 20 cycles after start.
    tok_if.tok_ready = 1'b0;
    salt = 12'($urandom);
    push_expected();
    rd0 = rd_cnt; d0 = done_cnt;
    pulse_start(t0);
    while (cyc - t0 < 20) begin
      @(posedge clk); #1;
    end
    chk("hold_reads", 32'(rd_cnt - rd0), 32'd2);
    chk("hold_rd_en", 32'(omem_rd_en), 32'd0);
    chk("hold_valid", 32'(tok_if.tok_valid), 32'd1);
    tok_if.tok_ready = 1'b1;
    rel = cyc;
    wait_done(t0, d0, 1'b0, -1, ok);
    if (ok) chk("hold_done_after_release", 32'(done_cyc - rel), 32'(WORDS));
    chk("hold_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a backpressured frame.
    salt = 12'($urandom);
    push_expected();
    pulse_start(t0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      tok_if.tok_ready = 1'($urandom_range(0, 1));
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fresh frame after reset: starts at address 0, no stale words.
    run_timed_frame("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
